// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants and the packed colour type.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_TOT  = 800;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_TOT  = 525;

  // Screen coordinates are 10 bits wide, enough for 800 columns and 525 lines.
  typedef logic [9:0] coord_t;

  // Two bits per colour component, packed {r,g,b} like the colour parameters.
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters plus sync, visibility and frame-sample decodes.
// Sync and colour decodes are combinational here; the top registers them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HVIS  = H_VIS,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HTOT  = H_TOT,
  parameter int VVIS  = V_VIS,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VTOT  = V_TOT
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   ena,
  output coord_t x,
  output coord_t y,
  output logic   hsync_n,
  output logic   vsync_n,
  output logic   visible,
  output logic   frame_sample
);

  // Advance x every enabled cycle; step y on the x wrap.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (ena) begin
      if (x == coord_t'(HTOT - 1)) begin
        x <= '0;
        y <= (y == coord_t'(VTOT - 1)) ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  // Decode syncs, the visible window and the once-per-frame level sample point.
  always_comb begin
    hsync_n      = !((x >= coord_t'(HVIS + HFP)) && (x <= coord_t'(HVIS + HFP + HSYNC - 1)));
    vsync_n      = !((y >= coord_t'(VVIS + VFP)) && (y <= coord_t'(VVIS + VFP + VSYNC - 1)));
    visible      = (x < coord_t'(HVIS)) && (y < coord_t'(VVIS));
    frame_sample = (x == '0) && (y == coord_t'(VVIS));
  end

endmodule

// File: rtl/vga_level_meter.sv
// Level-meter renderer: NCH bars with peak-hold markers over a checker background.
// Levels are captured once per frame at the first blanked line so bars never tear.
module vga_level_meter
  import vga_pkg::*;
#(
  parameter int         NCH         = 4,
  parameter int         LW          = 4,
  parameter int         CHW         = 128,
  parameter int         SPACE       = 26,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [5:0] BAR_COL     = 6'h3f,
  parameter logic [5:0] PEAK_COL    = 6'h30,
  parameter int         HVIS        = H_VIS,
  parameter int         HFP         = H_FP,
  parameter int         HSYNC       = H_SYNC,
  parameter int         HTOT        = H_TOT,
  parameter int         VVIS        = V_VIS,
  parameter int         VFP         = V_FP,
  parameter int         VSYNC       = V_SYNC,
  parameter int         VTOT        = V_TOT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic [NCH*LW-1:0] lvl,
  input  logic              peak_clr,
  output logic              frame_tick,
  output logic              hsync,
  output logic              vsync,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b
);

  localparam int STEP = CHW >> LW;
  localparam int CMAX = (CHW > SPACE) ? CHW : SPACE;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int SEGW = $clog2(NCH + 1);
  localparam int HW   = $clog2(HOLD_FRAMES + 1);

  coord_t x, y;
  logic   hsync_n, vsync_n, visible, frame_sample;

  vga_timing #(
    .HVIS(HVIS), .HFP(HFP), .HSYNC(HSYNC), .HTOT(HTOT),
    .VVIS(VVIS), .VFP(VFP), .VSYNC(VSYNC), .VTOT(VTOT)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .ena         (ena),
    .x           (x),
    .y           (y),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .visible     (visible),
    .frame_sample(frame_sample)
  );

  // Only y[6:1] feeds the background pattern.
  logic unused_y;
  assign unused_y = ^{y[9:7], y[0]};

  // Position of the current x within the gap/channel layout. cnt counts gap or
  // channel pixels, col is the level column (offset / STEP) kept by a sub-step counter.
  logic            in_ch;
  logic [CW-1:0]   cnt;
  logic [SEGW-1:0] seg;
  logic [SW-1:0]   sub;
  logic [LW-1:0]   col;

  // Walk gap -> channel -> gap along the line; everything restarts at x==0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ch <= 1'b0;
      cnt   <= '0;
      seg   <= '0;
      sub   <= '0;
      col   <= '0;
    end else if (ena) begin
      if (x == coord_t'(HTOT - 1)) begin
        in_ch <= 1'b0;
        cnt   <= '0;
        seg   <= '0;
        sub   <= '0;
        col   <= '0;
      end else if (!in_ch) begin
        sub <= '0;
        col <= '0;
        if (cnt == CW'(SPACE - 1)) begin
          cnt   <= '0;
          in_ch <= (seg < SEGW'(NCH));
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == CW'(CHW - 1)) begin
          cnt   <= '0;
          in_ch <= 1'b0;
          seg   <= seg + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (sub == SW'(STEP - 1)) begin
          sub <= '0;
          col <= col + 1'b1;
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end

  logic [LW-1:0] lvl_q [NCH];
  logic [LW-1:0] peak  [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [LW-1:0] lvl_in;
    logic [LW-1:0] lvl_r;
    logic [LW-1:0] peak_r;
    logic [HW-1:0] hold_r;

    assign lvl_in   = lvl[k*LW +: LW];
    assign lvl_q[k] = lvl_r;
    assign peak[k]  = peak_r;

    // Capture the level at the sample point and run the peak hold/decay; clear wins.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        lvl_r  <= '0;
        peak_r <= '0;
        hold_r <= '0;
      end else if (ena) begin
        if (frame_sample) lvl_r <= lvl_in;
        if (peak_clr) begin
          peak_r <= '0;
          hold_r <= '0;
        end else if (frame_sample) begin
          if (lvl_in >= peak_r) begin
            peak_r <= lvl_in;
            hold_r <= HW'(HOLD_FRAMES);
          end else if (hold_r != '0) begin
            hold_r <= hold_r - 1'b1;
          end else if (peak_r != '0) begin
            peak_r <= peak_r - 1'b1;
          end
        end
      end
    end
  end

  logic [LW-1:0] cur_lvl, cur_peak;
  logic [5:0]    bg;
  rgb_t          pix;

  // Select the active channel's level/peak and pick the pixel colour by priority.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_lvl  = '0;
    cur_peak = '0;
    for (int k = 0; k < NCH; k++) begin
      if (seg == SEGW'(k)) begin
        cur_lvl  = lvl_q[k];
        cur_peak = peak[k];
      end
    end
    bg  = (x[6:1] ^ y[6:1]) & 6'b011000;
    pix = rgb_t'(bg);
    if (!visible) begin
      pix = '0;
    end else if (in_ch && (col < cur_lvl)) begin
      pix = rgb_t'(BAR_COL);
    end else if (in_ch && (cur_peak != '0) && (col == cur_peak - 1'b1) && (cur_peak > cur_lvl)) begin
      pix = rgb_t'(PEAK_COL);
    end
  end

  // Register all outputs so they trail the counters by exactly one enabled cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      frame_tick <= 1'b0;
    end else if (ena) begin
      hsync      <= hsync_n;
      vsync      <= vsync_n;
      r          <= pix.r;
      g          <= pix.g;
      b          <= pix.b;
      frame_tick <= frame_sample;
    end
  end

endmodule
